// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM unified-memory arbiter.
// Holds the FSM state encoding, the grant encoding and the perf counter width.
package mem_arb_defs;

  localparam int unsigned PERF_W = 32;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2,
    I_DROP = 2'd3
  } arb_state_e;

  // Owner of the most recent grant
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_e;

endpackage : mem_arb_defs

// File: rtl/mem_arb_perf_cnt.sv
// Saturating event counter with enable, used by the arbiter's optional
// MEM_ARB_PERF_EN performance counters.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   en        : count this cycle
//   count     : current value, sticks at all-ones
module mem_arb_perf_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count up while enabled, hold at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule : mem_arb_perf_cnt

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (IF) and
// load/store (MEM) requesters, returns data with one-cycle acks, raises a
// pipeline stall request, and drops fetches cancelled by a redirect.
// Optional feature: define MEM_ARB_PERF_EN to add saturating wait/drop counters.
// Ports:
//   clk, rstn                         : clock, asynchronous active-low reset
//   if_req/if_addr/if_kill            : fetch request, PC, redirect cancel
//   if_ack/if_rdata                   : fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata         : load/store request
//   d_ack/d_rdata                     : load/store completion and load data
//   m_req/m_we/m_addr/m_wdata         : memory request, held until m_ready
//   m_rdata/m_ready                   : memory response
//   stall_pipe                        : combinational stall request
//   perf_if_wait/perf_d_wait/perf_drop: counters (MEM_ARB_PERF_EN only)
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              stall_pipe
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_if_wait,
  output logic [PERF_W-1:0] perf_d_wait,
  output logic [PERF_W-1:0] perf_drop
`endif
);

  arb_state_e        r_state,      w_state_nxt;
  grant_e            r_last_grant, w_last_grant_nxt;
  logic              r_m_req,      w_m_req_nxt;
  logic              r_m_we,       w_m_we_nxt;
  logic [ADDR_W-1:0] r_m_addr,     w_m_addr_nxt;
  logic [DATA_W-1:0] r_m_wdata,    w_m_wdata_nxt;
  logic              r_if_ack,     w_if_ack_nxt;
  logic [DATA_W-1:0] r_if_rdata,   w_if_rdata_nxt;
  logic              r_d_ack,      w_d_ack_nxt;
  logic [DATA_W-1:0] r_d_rdata,    w_d_rdata_nxt;

  logic w_if_elig;
  logic w_d_elig;

  // A requester acked this cycle is about to drop its req; a killed fetch is
  // never granted.
  assign w_if_elig = if_req & ~r_if_ack & ~if_kill;
  assign w_d_elig  = d_req  & ~r_d_ack;

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_last_grant <= GNT_IF;
      r_m_req      <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_if_ack     <= 1'b0;
      r_if_rdata   <= '0;
      r_d_ack      <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_m_req      <= w_m_req_nxt;
      r_m_we       <= w_m_we_nxt;
      r_m_addr     <= w_m_addr_nxt;
      r_m_wdata    <= w_m_wdata_nxt;
      r_if_ack     <= w_if_ack_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_ack      <= w_d_ack_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_m_req_nxt      = r_m_req;
    w_m_we_nxt       = r_m_we;
    w_m_addr_nxt     = r_m_addr;
    w_m_wdata_nxt    = r_m_wdata;
    w_if_rdata_nxt   = r_if_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_if_ack_nxt     = 1'b0;
    w_d_ack_nxt      = 1'b0;

    case (r_state)
      IDLE: begin
        // On a tie, the requester that did not win last time goes first
        if (w_d_elig && (!w_if_elig || (r_last_grant == GNT_IF))) begin
          w_m_req_nxt      = 1'b1;
          w_m_we_nxt       = d_we;
          w_m_addr_nxt     = d_addr;
          w_m_wdata_nxt    = d_wdata;
          w_last_grant_nxt = GNT_D;
          w_state_nxt      = D_BUSY;
        end else if (w_if_elig) begin
          w_m_req_nxt      = 1'b1;
          w_m_we_nxt       = 1'b0;
          w_m_addr_nxt     = if_addr;
          w_m_wdata_nxt    = '0;
          w_last_grant_nxt = GNT_IF;
          w_state_nxt      = I_BUSY;
        end
      end

      D_BUSY: begin
        if (m_ready) begin
          w_m_req_nxt = 1'b0;
          if (!r_m_we) begin
            w_d_rdata_nxt = m_rdata;
          end
          w_d_ack_nxt = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      I_BUSY: begin
        if (m_ready) begin
          w_m_req_nxt = 1'b0;
          w_state_nxt = IDLE;
          // A kill coinciding with completion discards the instruction
          if (!if_kill) begin
            w_if_rdata_nxt = m_rdata;
            w_if_ack_nxt   = 1'b1;
          end
        end else if (if_kill) begin
          w_state_nxt = I_DROP;
        end
      end

      I_DROP: begin
        // Memory must still finish the access; the result is thrown away
        if (m_ready) begin
          w_m_req_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign m_req    = r_m_req;
  assign m_we     = r_m_we;
  assign m_addr   = r_m_addr;
  assign m_wdata  = r_m_wdata;
  assign if_ack   = r_if_ack;
  assign if_rdata = r_if_rdata;
  assign d_ack    = r_d_ack;
  assign d_rdata  = r_d_rdata;

  assign stall_pipe = (if_req & ~r_if_ack) | (d_req & ~r_d_ack) | (r_state == I_DROP);

`ifdef MEM_ARB_PERF_EN
  logic w_if_wait_ev;
  logic w_d_wait_ev;
  logic w_drop_ev;

  // Both drop paths (enter I_DROP, or discard on completion) start in I_BUSY
  assign w_if_wait_ev = if_req & ~r_if_ack;
  assign w_d_wait_ev  = d_req & ~r_d_ack;
  assign w_drop_ev    = (r_state == I_BUSY) & if_kill;

  mem_arb_perf_cnt #(.W(PERF_W)) u_perf_if_wait (
    .clk   (clk),
    .rstn  (rstn),
    .en    (w_if_wait_ev),
    .count (perf_if_wait)
  );

  mem_arb_perf_cnt #(.W(PERF_W)) u_perf_d_wait (
    .clk   (clk),
    .rstn  (rstn),
    .en    (w_d_wait_ev),
    .count (perf_d_wait)
  );

  mem_arb_perf_cnt #(.W(PERF_W)) u_perf_drop (
    .clk   (clk),
    .rstn  (rstn),
    .en    (w_drop_ev),
    .count (perf_drop)
  );
`endif

endmodule : mem_port_arbiter

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline.
- Sequences memory transactions and returns read data plus one-cycle acks to each requester.
- Drives a pipeline stall request that the hazard logic ORs into its stall_if/stall_id/stall_ex outputs.
- Cancels in-flight fetches when the pipeline redirects on a taken branch or jump.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
if_req  in  1  fetch request; level, held until if_ack
if_addr  in  ADDR_W  fetch address (PC)
if_kill  in  1  pulse; discard any in-flight fetch (branch/jump redirect)
if_ack  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; level, held until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse; d_rdata valid for loads
d_rdata  out  DATA_W  load data
m_req  out  1  memory request, held until m_ready
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid when m_ready = 1
m_ready  in  1  memory completion, one cycle
stall_pipe  out  1  pipeline stall request

Behaviour:
- Clock and reset: single clock clk; reset rstn is asynchronous and active-low.
- Reset values:
  - state = IDLE; last_grant = IF, so data wins the first tie.
  - All outputs are 0, including both rdata registers.
  - Reset mid-transaction abandons the transaction with no ack.
- FSM states: IDLE, D_BUSY, I_BUSY, I_DROP.
- IDLE:
  - An eligible requester is one whose req = 1 and whose ack is not asserted this cycle. This prevents re-issuing a request the requester is about to drop.
  - Both eligible: grant the requester that is not last_grant.
  - One eligible: grant it.
  - On grant, register m_req = 1 and m_we/m_addr/m_wdata from that requester. For an IF grant, m_we = 0. Update last_grant and move to D_BUSY or I_BUSY.
  - An IF grant is suppressed if if_kill = 1 in the same cycle.
- D_BUSY / I_BUSY:
  - m_req and the address/data outputs stay stable.
  - On m_ready: drop m_req, register the owner's rdata from m_rdata, pulse its ack next cycle, return to IDLE.
  - d_rdata updates only on loads; for stores it holds its previous value.
- I_BUSY with if_kill:
  - if_kill without m_ready moves to I_DROP.
  - if_kill in the same cycle as m_ready: result discarded, no if_ack, go to IDLE.
- I_DROP: m_req stays held; on m_ready go to IDLE with no if_ack and if_rdata unchanged.
- Latency: request seen at cycle 0 → m_req at cycle 1 → m_ready at cycle k ≥ 1 → ack at cycle k+1.
- Back-to-back: after an ack, the other pending requester is granted in the IDLE cycle that coincides with the ack. No idle bubble.
- stall_pipe (combinational) = (if_req & ~if_ack) | (d_req & ~d_ack) | (state == I_DROP).
- if_kill while IDLE or D_BUSY has no effect on the FSM.
- Each ack is high for exactly one cycle. if_ack and d_ack are never high together.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds output ports perf_if_wait[31:0], perf_d_wait[31:0] and perf_drop[31:0].
  - perf_if_wait counts cycles with if_req & ~if_ack.
  - perf_d_wait counts cycles with d_req & ~d_ack.
  - perf_drop counts killed fetches, incremented on entry to I_DROP or on the kill-with-m_ready discard.
  - Counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header/package mem_arb_defs: state encodings (IDLE = 2'd0, D_BUSY = 2'd1, I_BUSY = 2'd2, I_DROP = 2'd3) and grant encodings (GNT_IF = 1'b0, GNT_D = 1'b1).
- One sub-module: mem_arb_perf_cnt, a saturating 32-bit counter with enable. It is instantiated three times, only under MEM_ARB_PERF_EN.

Test Plan:
1. Reset with if_req = 1 held; memory ready after 1 cycle → m_req at cycle 1, m_addr = if_addr, if_ack at cycle 3 with if_rdata = m_rdata; stall_pipe high until the ack cycle.
2. if_req and d_req raised in the same cycle after reset, store to 0x100 of 0xDEADBEEF → data granted first (m_we = 1, m_wdata = 0xDEADBEEF); d_ack pulses; IF is granted in the d_ack cycle and if_ack follows.
3. Load then fetch repeatedly with both reqs held → grants alternate D, I, D, I; no requester is ever granted twice in a row while the other waits.
4. Fetch with memory latency 4; if_kill at cycle 2 → state I_DROP; no if_ack; if_rdata unchanged; stall_pipe high until m_ready; a new if_req afterwards completes normally.
5. if_kill in the same cycle as m_ready in I_BUSY → no if_ack; state IDLE next cycle; perf_drop = 1 when MEM_ARB_PERF_EN is defined.
6. rstn asserted mid D_BUSY → m_req, d_ack and if_ack go to 0 immediately; after release, a held d_req is re-issued from IDLE.
